// File: rtl/fx2_pkg.sv
// fx2_pkg: shared definitions for the FX2 slave-FIFO bus arbiter.
//   FIFOADR_* : endpoint select codes driven on fifoadr
//   fx2_state_t : arbiter FSM states
package fx2_pkg;

   localparam logic [1:0] FIFOADR_EP2 = 2'b00;
   localparam logic [1:0] FIFOADR_EP6 = 2'b10;
   localparam logic [1:0] FIFOADR_EP8 = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_SETUP,
      ST_RD,
      ST_TURN,
      ST_WR,
      ST_PKT
   } fx2_state_t;

endpackage

// File: rtl/fx2_in_channel.sv
// fx2_in_channel: per-endpoint helper for one FX2 IN endpoint (EP6 or EP8).
// Ports:
//   ifclk, reset_n    : interface clock, asynchronous active-low reset
//   data/valid        : producer byte stream
//   flag              : FX2 endpoint not-full flag
//   commit            : one-cycle PKTEND request from the producer
//   active            : this channel owns the bus and the arbiter is in WR
//   burst_ok          : burst counter below the limit
//   clear_pending     : arbiter is issuing PKTEND for this channel
//   ready             : byte accepted this cycle (combinational)
//   eligible          : channel wants a grant
//   pending           : commit-pending bit
//   sel_data          : data when active, zero otherwise (OR-combined upstream)
module fx2_in_channel (
   input  logic       ifclk,
   input  logic       reset_n,
   input  logic [7:0] data,
   input  logic       valid,
   input  logic       flag,
   input  logic       commit,
   input  logic       active,
   input  logic       burst_ok,
   input  logic       clear_pending,
   output logic       ready,
   output logic       eligible,
   output logic       pending,
   output logic [7:0] sel_data
);

   logic pending_reg;

   // A new commit wins over the clear, so a pulse arriving while PKTEND is
   // being issued survives for the next grant.
   always_ff @(posedge ifclk or negedge reset_n) begin
      if (!reset_n)
         pending_reg <= 1'b0;
      else if (commit)
         pending_reg <= 1'b1;
      else if (clear_pending)
         pending_reg <= 1'b0;
   end

   assign pending  = pending_reg;
   assign eligible = (valid & flag) | pending_reg;
   assign ready    = active & valid & flag & burst_ok;
   assign sel_data = active ? data : 8'h00;

endmodule

// File: rtl/fx2_bus_arbiter.sv
// fx2_bus_arbiter: FPGA-side master for the FX2 slave-FIFO bus. Time-shares fd
// between the EP2 command reader and the EP6/EP8 data writers, sequencing the
// strobes with a turnaround cycle between every transfer.
// Ports:
//   ifclk, reset_n               : interface clock, asynchronous active-low reset
//   fd                           : bidirectional FX2 data bus
//   sloe, slrd, slwr, pktend     : FX2 strobes, active-low
//   fifoadr                      : endpoint select
//   flags                        : [0] EP2 not-empty, [1] EP6 not-full, [2] EP8 not-full
//   cmd_data/cmd_valid/cmd_ready : command byte stream out of EP2
//   epN_data/valid/ready/commit  : IN endpoint producers (N = 6, 8)
module fx2_bus_arbiter
   import fx2_pkg::*;
#(
   parameter int unsigned MAX_BURST = 64
) (
   input  logic       ifclk,
   input  logic       reset_n,
   inout  wire  [7:0] fd,
   output logic       sloe,
   output logic       slrd,
   output logic       slwr,
   output logic       pktend,
   output logic [1:0] fifoadr,
   input  logic [2:0] flags,
   output logic [7:0] cmd_data,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   input  logic [7:0] ep6_data,
   input  logic       ep6_valid,
   output logic       ep6_ready,
   input  logic       ep6_commit,
   input  logic [7:0] ep8_data,
   input  logic       ep8_valid,
   output logic       ep8_ready,
   input  logic       ep8_commit
);

   localparam int BURST_W = $clog2(MAX_BURST + 1);

   fx2_state_t         state_reg;
   logic [1:0]         fifoadr_reg;
   logic               sloe_reg, slwr_reg, pktend_reg;
   logic [7:0]         fd_out_reg;
   logic               fd_oe_reg;
   logic [BURST_W-1:0] burst_reg;
   logic               rr_reg;      // 1: EP8 preferred on the next tie
   logic               grant8_reg;  // channel owning the write path (0 EP6, 1 EP8)
   logic [7:0]         cmd_data_reg;
   logic               cmd_valid_reg;

   // Channel index 0 = EP6, 1 = EP8
   logic [7:0] ch_data     [2];
   logic [7:0] ch_sel_data [2];
   logic [1:0] ch_valid, ch_flag, ch_commit, ch_active, ch_clear;
   logic [1:0] ch_ready, ch_eligible, ch_pending;

   logic burst_ok, rd_strobe, wr_accept, cur_pending, pick8;
   logic [7:0] wr_data;

   assign ch_data[0] = ep6_data;
   assign ch_data[1] = ep8_data;
   assign ch_valid   = {ep8_valid, ep6_valid};
   assign ch_flag    = flags[2:1];
   assign ch_commit  = {ep8_commit, ep6_commit};

   assign burst_ok = burst_reg < BURST_W'(MAX_BURST);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ch
         assign ch_active[gi] = (state_reg == ST_WR)  && (grant8_reg == 1'(gi));
         assign ch_clear[gi]  = (state_reg == ST_PKT) && (grant8_reg == 1'(gi));

         fx2_in_channel u_ch (
            .ifclk         (ifclk),
            .reset_n       (reset_n),
            .data          (ch_data[gi]),
            .valid         (ch_valid[gi]),
            .flag          (ch_flag[gi]),
            .commit        (ch_commit[gi]),
            .active        (ch_active[gi]),
            .burst_ok      (burst_ok),
            .clear_pending (ch_clear[gi]),
            .ready         (ch_ready[gi]),
            .eligible      (ch_eligible[gi]),
            .pending       (ch_pending[gi]),
            .sel_data      (ch_sel_data[gi])
         );
      end
   endgenerate

   assign wr_accept   = |ch_ready;
   assign wr_data     = ch_sel_data[0] | ch_sel_data[1];
   assign cur_pending = ch_pending[grant8_reg];
   assign pick8       = ch_eligible[1] & (~ch_eligible[0] | rr_reg);

   // slrd is combinational so a falling cmd_ready or EP2 flag stops the read
   // on the very edge it is seen.
   assign rd_strobe = (state_reg == ST_RD) & flags[0] & cmd_ready & burst_ok;

   assign slrd      = ~rd_strobe;
   assign sloe      = sloe_reg;
   assign slwr      = slwr_reg;
   assign pktend    = pktend_reg;
   assign fifoadr   = fifoadr_reg;
   assign ep6_ready = ch_ready[0];
   assign ep8_ready = ch_ready[1];
   assign cmd_data  = cmd_data_reg;
   assign cmd_valid = cmd_valid_reg;
   assign fd        = fd_oe_reg ? fd_out_reg : 8'bz;

   always_ff @(posedge ifclk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= ST_IDLE;
         fifoadr_reg <= FIFOADR_EP2;
         sloe_reg    <= 1'b1;
         slwr_reg    <= 1'b1;
         pktend_reg  <= 1'b1;
         fd_out_reg  <= 8'h00;
         fd_oe_reg   <= 1'b0;
         burst_reg   <= '0;
         rr_reg      <= 1'b0;
         grant8_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (flags[0] && cmd_ready) begin
                  fifoadr_reg <= FIFOADR_EP2;
                  sloe_reg    <= 1'b0;
                  state_reg   <= ST_RD_SETUP;
               end else if (|ch_eligible) begin
                  fifoadr_reg <= pick8 ? FIFOADR_EP8 : FIFOADR_EP6;
                  grant8_reg  <= pick8;
                  rr_reg      <= ~pick8;
                  burst_reg   <= '0;
                  state_reg   <= ST_WR;
               end
            end
            ST_RD_SETUP: begin
               burst_reg <= '0;
               state_reg <= ST_RD;
            end
            ST_RD: begin
               if (rd_strobe) begin
                  burst_reg <= burst_reg + 1'b1;
               end else begin
                  sloe_reg  <= 1'b1;
                  state_reg <= ST_TURN;
               end
            end
            ST_WR: begin
               if (wr_accept) begin
                  fd_out_reg <= wr_data;
                  fd_oe_reg  <= 1'b1;
                  slwr_reg   <= 1'b0;
                  burst_reg  <= burst_reg + 1'b1;
               end else begin
                  // The last byte's strobe is in this cycle; release it here.
                  slwr_reg  <= 1'b1;
                  fd_oe_reg <= 1'b0;
                  if (cur_pending) begin
                     pktend_reg <= 1'b0;
                     state_reg  <= ST_PKT;
                  end else begin
                     state_reg  <= ST_TURN;
                  end
               end
            end
            ST_PKT: begin
               pktend_reg <= 1'b1;
               state_reg  <= ST_TURN;
            end
            ST_TURN: begin
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Read capture: a byte stays presented until the decoder takes it. A new
   // sample needs cmd_ready high, which also consumes the previous byte.
   always_ff @(posedge ifclk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_data_reg  <= 8'h00;
         cmd_valid_reg <= 1'b0;
      end else if (rd_strobe) begin
         cmd_data_reg  <= fd;
         cmd_valid_reg <= 1'b1;
      end else if (cmd_ready) begin
         cmd_valid_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fx2_bus_arbiter.sv
// tb_fx2_bus_arbiter: directed bench for fx2_bus_arbiter with a small FX2
// slave-FIFO model (EP2 source, EP6/EP8 sinks), byte producers and a decoder.
module tb_fx2_bus_arbiter;

   logic       ifclk   = 1'b0;
   logic       reset_n = 1'b1;
   wire  [7:0] fd;
   logic       sloe, slrd, slwr, pktend;
   logic [1:0] fifoadr;
   logic [2:0] flags;
   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready = 1'b1;
   logic [7:0] ep6_data, ep8_data;
   logic       ep6_valid, ep6_ready, ep6_commit;
   logic       ep8_valid, ep8_ready, ep8_commit;

   int   ep2_len = 0, ep2_idx = 0;
   int   ep6_len = 0, ep6_idx = 0;
   int   ep8_len = 0, ep8_idx = 0;
   logic ep6_nf = 1'b1, ep8_nf = 1'b1;
   logic ep6_cpulse = 1'b0, ep8_commit_last = 1'b0;
   logic [7:0] ep2_byte;

   int n_assert = 0, n_fail = 0;

   logic [7:0] cmd_log[$], ep6_log[$], ep8_log[$];
   int   pkt_log[$], burst_len_q[$], burst_adr_q[$];
   int   slrd_cnt = 0, slrd_bad = 0, contention = 0, conflict = 0;
   logic in_burst = 1'b0;
   int   cur_len = 0, cur_adr = 0;

   always #5 ifclk = ~ifclk;

   fx2_bus_arbiter #(.MAX_BURST(64)) dut (
      .ifclk      (ifclk),
      .reset_n    (reset_n),
      .fd         (fd),
      .sloe       (sloe),
      .slrd       (slrd),
      .slwr       (slwr),
      .pktend     (pktend),
      .fifoadr    (fifoadr),
      .flags      (flags),
      .cmd_data   (cmd_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .ep6_data   (ep6_data),
      .ep6_valid  (ep6_valid),
      .ep6_ready  (ep6_ready),
      .ep6_commit (ep6_commit),
      .ep8_data   (ep8_data),
      .ep8_valid  (ep8_valid),
      .ep8_ready  (ep8_ready),
      .ep8_commit (ep8_commit)
   );

   // FX2 model: EP2 holds bytes 1,2,3,...; drives fd while sloe is low.
   assign ep2_byte = 8'(ep2_idx + 1);
   assign fd       = (!sloe) ? ep2_byte : 8'bz;
   assign flags    = {ep8_nf, ep6_nf, (ep2_idx < ep2_len)};

   // Producers: EP6 sends 1,2,3,... ; EP8 sends 0x81,0x82,...
   assign ep6_valid  = ep6_idx < ep6_len;
   assign ep8_valid  = ep8_idx < ep8_len;
   assign ep6_data   = 8'(ep6_idx + 1);
   assign ep8_data   = 8'(ep8_idx + 129);
   assign ep6_commit = ep6_cpulse;
   assign ep8_commit = ep8_commit_last && ep8_valid && ep8_ready && (ep8_idx == ep8_len - 1);

   always @(posedge ifclk) begin
      if (!slrd) ep2_idx <= ep2_idx + 1;
      if (ep6_valid && ep6_ready) ep6_idx <= ep6_idx + 1;
      if (ep8_valid && ep8_ready) ep8_idx <= ep8_idx + 1;
   end

   // Bus monitor and logs
   always @(posedge ifclk) begin
      if (cmd_valid && cmd_ready) cmd_log.push_back(cmd_data);
      if (!slrd) begin
         slrd_cnt <= slrd_cnt + 1;
         if (fifoadr != 2'b00) slrd_bad <= slrd_bad + 1;
      end
      if (!slwr) begin
         if (fifoadr == 2'b10) ep6_log.push_back(fd);
         else if (fifoadr == 2'b11) ep8_log.push_back(fd);
      end
      if (!pktend) pkt_log.push_back(int'(fifoadr));
      if (!sloe && (dut.fd_oe_reg || !slwr)) contention <= contention + 1;
      if ((!pktend && !slwr) || (!slrd && !slwr)) conflict <= conflict + 1;
      if (!slwr) begin
         if (in_burst) cur_len <= cur_len + 1;
         else begin
            in_burst <= 1'b1;
            cur_len  <= 1;
            cur_adr  <= int'(fifoadr);
         end
      end else if (in_burst) begin
         in_burst <= 1'b0;
         burst_len_q.push_back(cur_len);
         burst_adr_q.push_back(cur_adr);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // which: 0 = slwr, 1 = pktend. Returns at posedge+1 of the first low sample.
   task automatic wait_low(input int which, input int max_cycles, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         @(posedge ifclk); #1;
         if ((which == 0 && !slwr) || (which == 1 && !pktend)) seen = 1'b1;
      end
   endtask

   initial begin
      bit seen;
      int bad;

      // ---- reset state ----
      #1 reset_n = 1'b0;
      #1;
      check("rst_sloe",    32'(sloe),      32'd1);
      check("rst_slrd",    32'(slrd),      32'd1);
      check("rst_slwr",    32'(slwr),      32'd1);
      check("rst_pktend",  32'(pktend),    32'd1);
      check("rst_fifoadr", 32'(fifoadr),   32'd0);
      check("rst_cmdv",    32'(cmd_valid), 32'd0);
      check("rst_ready",   32'({ep6_ready, ep8_ready}), 32'd0);
      check("rst_fd_oe",   32'(dut.fd_oe_reg), 32'd0);
      repeat (2) @(negedge ifclk);
      reset_n = 1'b1;
      repeat (2) @(negedge ifclk);

      // ---- EP2 read of 3 bytes ----
      ep2_len = 3;
      @(posedge ifclk); #1;
      check("rd_setup_sloe", 32'(sloe),    32'd0);
      check("rd_setup_slrd", 32'(slrd),    32'd1);
      check("rd_setup_adr",  32'(fifoadr), 32'd0);
      @(posedge ifclk); #1;
      check("rd_first_slrd", 32'(slrd), 32'd0);
      @(posedge ifclk); #1;
      check("rd_first_cmdv", 32'(cmd_valid), 32'd1);
      check("rd_first_cmdd", 32'(cmd_data),  32'h01);
      repeat (8) @(negedge ifclk);
      check("rd_slrd_cnt", 32'(slrd_cnt), 32'd3);
      check("rd_slrd_adr", 32'(slrd_bad), 32'd0);
      check("rd_log_size", 32'(cmd_log.size()), 32'd3);
      check("rd_log_b0", 32'(cmd_log[0]), 32'h01);
      check("rd_log_b1", 32'(cmd_log[1]), 32'h02);
      check("rd_log_b2", 32'(cmd_log[2]), 32'h03);

      // ---- cmd_ready falling mid-read ----
      ep2_len = 5;
      repeat (3) @(posedge ifclk);
      @(negedge ifclk);
      cmd_ready = 1'b0;
      #1;
      check("rdy_stop_slrd", 32'(slrd),      32'd1);
      check("rdy_stop_cmdv", 32'(cmd_valid), 32'd1);
      check("rdy_stop_cmdd", 32'(cmd_data),  32'h04);
      @(posedge ifclk); #1;
      check("rdy_hold_cmdv", 32'(cmd_valid), 32'd1);
      check("rdy_hold_cmdd", 32'(cmd_data),  32'h04);
      @(negedge ifclk);
      cmd_ready = 1'b1;
      repeat (12) @(negedge ifclk);
      check("rdy_log_size", 32'(cmd_log.size()), 32'd5);
      check("rdy_log_b3",   32'(cmd_log[3]), 32'h04);
      check("rdy_log_b4",   32'(cmd_log[4]), 32'h05);
      check("rdy_slrd_cnt", 32'(slrd_cnt), 32'd5);

      // ---- EP6 stream of 130 bytes: bursts 64,64,2 ----
      ep6_len = 130;
      repeat (200) @(negedge ifclk);
      check("ep6_log_size", 32'(ep6_log.size()), 32'd130);
      bad = 0;
      for (int i = 0; i < ep6_log.size(); i++) if (ep6_log[i] !== 8'(i + 1)) bad++;
      check("ep6_order", 32'(bad), 32'd0);
      check("b0_len", 32'(burst_len_q[0]), 32'd64);
      check("b1_len", 32'(burst_len_q[1]), 32'd64);
      check("b2_len", 32'(burst_len_q[2]), 32'd2);
      check("b012_adr", 32'({burst_adr_q[0][1:0], burst_adr_q[1][1:0], burst_adr_q[2][1:0]}), 32'b101010);

      // ---- EP8: commit with 5th byte ----
      ep8_commit_last = 1'b1;
      ep8_len = 5;
      wait_low(1, 40, seen);
      check("ep8_pkt_seen", 32'(seen), 32'd1);
      check("ep8_pkt_adr",  32'(fifoadr), 32'd3);
      check("ep8_pkt_slwr", 32'(slwr), 32'd1);
      @(posedge ifclk); #1;
      check("ep8_turn_strobes", 32'({sloe, slrd, slwr, pktend}), 32'hF);
      ep8_commit_last = 1'b0;
      repeat (5) @(negedge ifclk);
      check("ep8_log_size", 32'(ep8_log.size()), 32'd5);
      check("ep8_b4", 32'(ep8_log[4]), 32'h85);
      check("b3_len", 32'(burst_len_q[3]), 32'd5);
      check("pkt_log_size", 32'(pkt_log.size()), 32'd1);
      check("pkt_log_0", 32'(pkt_log[0]), 32'd3);

      // ---- EP6 and EP8 both busy: grants alternate 10,11,10,11 ----
      ep6_len = ep6_len + 128;
      ep8_len = ep8_len + 128;
      repeat (320) @(negedge ifclk);
      check("alt_adr", 32'({burst_adr_q[4][1:0], burst_adr_q[5][1:0],
                             burst_adr_q[6][1:0], burst_adr_q[7][1:0]}), 32'b10111011);
      check("alt_len", 32'(burst_len_q[4] + burst_len_q[5] + burst_len_q[6] + burst_len_q[7]), 32'd256);
      check("alt_ep6_size", 32'(ep6_log.size()), 32'd258);
      check("alt_ep8_size", 32'(ep8_log.size()), 32'd133);
      bad = 0;
      for (int i = 0; i < ep6_log.size(); i++) if (ep6_log[i] !== 8'(i + 1)) bad++;
      for (int i = 0; i < ep8_log.size(); i++) if (ep8_log[i] !== 8'(i + 129)) bad++;
      check("alt_order", 32'(bad), 32'd0);
      check("alt_contention", 32'(contention), 32'd0);

      // ---- EP6 commit with no data: zero-length packet ----
      ep6_cpulse = 1'b1;
      @(negedge ifclk);
      ep6_cpulse = 1'b0;
      wait_low(1, 20, seen);
      check("zlp_seen", 32'(seen), 32'd1);
      check("zlp_adr",  32'(fifoadr), 32'd2);
      repeat (5) @(negedge ifclk);
      check("zlp_pkt_cnt", 32'(pkt_log.size()), 32'd2);
      check("zlp_pkt_adr", 32'(pkt_log[1]), 32'd2);
      check("zlp_no_slwr", 32'(ep6_log.size()), 32'd258);

      // ---- reset mid-write burst ----
      ep6_len = ep6_len + 20;
      wait_low(0, 20, seen);
      check("mid_wr_seen", 32'(seen), 32'd1);
      repeat (3) @(posedge ifclk);
      #3 reset_n = 1'b0;
      #1;
      check("arst_strobes", 32'({sloe, slrd, slwr, pktend}), 32'hF);
      check("arst_ready",   32'(ep6_ready), 32'd0);
      check("arst_fd_oe",   32'(dut.fd_oe_reg), 32'd0);
      repeat (2) @(negedge ifclk);
      reset_n = 1'b1;
      wait_low(0, 20, seen);
      check("resume_seen", 32'(seen), 32'd1);
      check("resume_adr",  32'(fifoadr), 32'd2);
      repeat (40) @(negedge ifclk);
      check("resume_drained", 32'(ep6_idx), 32'(ep6_len));
      check("strobe_conflict", 32'(conflict), 32'd0);
      check("final_contention", 32'(contention), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
